mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MAR/MDR register pair plus RAM access sequencer, directly downstream of the control unit.
//  Consumes the control unit's MARin, MDRin, Read and ramWE strobes and runs req/ack transactions to the RAM.
//  Returns MDR contents for the datapath bus mux. Provides mem_busy as the stall input for the control unit.
// PARAMETERS
//  DATA_W   32  width of the bus, MDR and RAM data
//  ADDR_W    9  MAR / RAM word-address width (512 words)
//  TIMEOUT  15  max cycles mem_req is held without mem_ack before the access is aborted
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       asynchronous, active-low reset
//  bus_in     in   DATA_W  datapath bus value (source for MAR and MDR loads)
//  MARin      in   1       load MAR from bus_in[ADDR_W-1:0]
//  MDRin      in   1       load MDR: from bus_in if Read=0; start RAM read if Read=1
//  Read       in   1       selects the memory read path for MDRin
//  ramWE      in   1       start RAM write of MDR to address MAR
//  mdr_out    out  DATA_W  current MDR contents (BusMux MDR input)
//  mar_out    out  ADDR_W  current MAR contents
//  mem_req    out  1       registered request; held high until ack or timeout
//  mem_we     out  1       1 = write transaction, 0 = read transaction; valid while mem_req=1
//  mem_addr   out  ADDR_W  address latched when the request is accepted
//  mem_wdata  out  DATA_W  MDR value latched when a write request is accepted
//  mem_rdata  in   DATA_W  RAM read data; sampled on the edge where mem_ack=1
//  mem_ack    in   1       RAM completion; ignored while mem_req=0
//  mem_busy   out  1       1 whenever the FSM is not in IDLE (combinational from state)
//  mem_done   out  1       one-cycle pulse after a transaction completes with ack
//  bus_err    out  1       sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  - Reset (rst=0, async): FSM=IDLE, MAR=0, MDR=0; all outputs 0. mem_req drops immediately,
//    including mid-transaction. The aborted transaction is not resumed.
//  - FSM states: IDLE, RD, WR.
//  - IDLE:
//    ramWE=1 -> WR. Write has priority if ramWE and MDRin&Read are both asserted.
//    MDRin&Read (and no ramWE) -> RD.
//    MDRin&!Read: MDR<=bus_in on the same edge (1-cycle load), stay in IDLE.
//  - MARin: MAR<=bus_in[ADDR_W-1:0] in any state. mem_addr is unaffected once a request is latched.
//  - On entry to RD/WR: mem_req=1, mem_we set, mem_addr<=MAR, mem_wdata<=MDR (WR), timeout counter<=0.
//  - RD/WR with mem_ack=1: RD loads MDR<=mem_rdata; then ->IDLE, mem_req=0 and mem_done=1 for one cycle.
//  - Minimum latency: request seen at edge N, ack sampled at edge N+1, MDR valid and mem_done=1 after N+1.
//  - RD/WR without ack: counter increments each cycle. When counter==TIMEOUT-1 with no ack:
//    ->IDLE, bus_err<=1, MDR unchanged, no mem_done.
//  - While busy: MDRin, Read and ramWE are ignored (no MDR load, no new request).
//    The control unit must stall on mem_busy.
//  - mem_ack on the same edge as a timeout: ack wins, no error.
//  - Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
// STRUCTURE
//  - Shared cpu_defs package/header: DATA_W, ADDR_W defaults and the FSM state encodings
//    (IDLE=2'd0, RD=2'd1, WR=2'd2).
//  - One sub-module: mem_timeout_ctr (clear, enable, TIMEOUT param, expired output).
//  - MAR/MDR registers and FSM stay in this top module.
// TESTING
//  1. Reset: drive rst=0 mid-RD with mem_req=1 -> mem_req, mem_busy, mdr_out, mar_out all 0 immediately.
//  2. bus_in=0x0000_0055, MARin -> mar_out=0x055. Then bus_in=0xDEAD_BEEF, MDRin, Read=0
//     -> mdr_out=0xDEADBEEF next cycle, mem_req stays 0.
//  3. Read from MAR=0x055, RAM acks after 3 cycles with 0x1234_5678 -> mem_addr=0x055, mem_we=0,
//     mem_busy high for 4 cycles, mdr_out=0x12345678, mem_done single pulse.
//  4. MDR=0xCAFE_0001, MAR=0x1FF, ramWE -> mem_we=1, mem_wdata=0xCAFE0001, mem_addr=0x1FF.
//     MARin to 0x010 mid-access -> mem_addr stays 0x1FF until ack.
//  5. No ack for 15 cycles on a read -> bus_err=1 (sticky), MDR unchanged, mem_done=0, back in IDLE.
//     Next access proceeds normally.
//  6. ramWE with MDRin&Read in the same IDLE cycle -> write issued.
//     MDRin&Read while busy is ignored (no second request).

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: default widths, timeout and FSM encodings.
package mem_access_unit_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned TIMEOUT_DEF = 15;

  // Encodings are fixed so they stay compatible with existing control-unit decode.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } mau_state_t;

  // Width needed to hold 0..timeout without wrapping.
  function automatic int unsigned ctr_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Saturating cycle counter that flags when a RAM access has waited TIMEOUT cycles.
module mem_timeout_ctr
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned   CW   = ctr_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] count;

  // Count waiting cycles; clear wins, and the count holds at MAX instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != MAX)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR register pair and req/ack RAM access sequencer feeding the datapath bus mux.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              ramWE,
  output logic [DATA_W-1:0] mdr_out,
  output logic [ADDR_W-1:0] mar_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              bus_err
);

  mau_state_t        state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              idle;
  logic              start_wr;
  logic              start_rd;
  logic              mdr_load;
  logic              expired;

  assign idle     = (state == IDLE);
  // Write takes priority over a read strobe in the same cycle; strobes are ignored while busy.
  assign start_wr = idle & ramWE;
  assign start_rd = idle & MDRin & Read & ~ramWE;
  assign mdr_load = idle & MDRin & ~Read & ~ramWE;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_wr | start_rd),
    .enable  (~idle & ~mem_ack),
    .expired (expired)
  );

  // MAR loads from the bus in any state; the in-flight address is held separately in mem_addr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar <= '0;
    end else if (MARin) begin
      mar <= bus_in[ADDR_W-1:0];
    end
  end

  // MDR loads from the bus when idle, or from RAM on an acknowledged read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdr <= '0;
    end else if (mdr_load) begin
      mdr <= bus_in;
    end else if ((state == RD) && mem_ack) begin
      mdr <= mem_rdata;
    end
  end

  // Access sequencer: latch the request on acceptance, finish on ack, abort on timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_done  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_wr) begin
            state     <= WR;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= mar;
            mem_wdata <= mdr;
          end else if (start_rd) begin
            state    <= RD;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= mar;
          end
        end
        RD, WR: begin
          // An ack on the timeout edge still completes the access.
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_done <= 1'b1;
          end else if (expired) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_busy = ~idle;
  assign mdr_out  = mdr;
  assign mar_out  = mar;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: stimulus acts as control unit and RAM, monitor checks each completed access.
module tb_mem_access_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_in = '0;
  logic        MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, ramWE = 1'b0;
  logic [31:0] mdr_out;
  logic [8:0]  mar_out;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_busy, mem_done, bus_err;

  mem_access_unit #(.DATA_W(32), .ADDR_W(9), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .ramWE(ramWE), .mdr_out(mdr_out), .mar_out(mar_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_busy(mem_busy),
    .mem_done(mem_done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] mdr;
    bit          to;
    bit          err;
    int          cycles;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          mon_en   = 1'b0;

  // Reference model state
  logic [8:0]  m_mar = '0;
  logic [31:0] m_mdr = '0;
  bit          m_err = 1'b0;
  logic [31:0] ram [512];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares each request against the queue head, pops when the request drops.
  bit   prev_req  = 1'b0;
  bit   prev_done = 1'b0;
  int   cyc       = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_done) check("done_single_pulse", mem_done, 0);
      check("busy_tracks_req", mem_busy, mem_req);
      if (mem_req && !prev_req) begin
        cyc = 0;
        check("req_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          check("req_we", mem_we, q[0].we);
          check("req_addr", mem_addr, q[0].addr);
          if (q[0].we) check("req_wdata", mem_wdata, q[0].wdata);
        end
      end
      if (mem_req) begin
        cyc++;
        if (q.size() > 0) check("addr_hold", mem_addr, q[0].addr);
      end
      if (!mem_req && prev_req) begin
        check("complete_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          cur = q.pop_front();
          check("busy_cycles", cyc, cur.cycles);
          check("done_on_ack", mem_done, !cur.to);
          check("bus_err", bus_err, cur.err);
          check("mdr_after", mdr_out, cur.mdr);
        end
      end else if (!mem_req && !prev_req) begin
        check("no_spurious_done", mem_done, 0);
      end
    end
    prev_req  = mem_req;
    prev_done = mem_done;
  end

  task automatic set_mar(input logic [31:0] v);
    bus_in = v; MARin = 1'b1;
    @(posedge clk); @(negedge clk);
    MARin = 1'b0;
    m_mar = v[8:0];
    check("mar_load", mar_out, m_mar);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    bus_in = v; MDRin = 1'b1; Read = 1'b0;
    @(posedge clk); @(negedge clk);
    MDRin = 1'b0;
    m_mdr = v;
    check("mdr_load", mdr_out, m_mdr);
    check("mdr_load_no_req", mem_req, 0);
  endtask

  task automatic clear_strobes();
    mem_ack = 1'b0; MDRin = 1'b0; Read = 1'b0; ramWE = 1'b0; MARin = 1'b0;
  endtask

  // One access: d = cycles of mem_req before ack is presented (d >= TO means never).
  task automatic access(input bit we, input bit both, input int d, input bit junk, input int mid_mar);
    exp_t        e;
    logic [31:0] rd;
    logic [31:0] r32;
    bit          we_eff;
    int          k;
    we_eff   = we | both;
    e.we     = we_eff;
    e.addr   = m_mar;
    e.wdata  = m_mdr;
    e.to     = (d >= TO);
    e.cycles = e.to ? TO : d + 1;
    rd       = ram[e.addr];
    if (!e.to) begin
      if (we_eff) ram[e.addr] = m_mdr;
      else m_mdr = ram[e.addr];
    end
    m_err  = m_err | e.to;
    e.mdr  = m_mdr;
    e.err  = m_err;
    q.push_back(e);

    ramWE  = we_eff;
    MDRin  = !we_eff || both;
    Read   = !we_eff || both;
    bus_in = $urandom;
    @(posedge clk); @(negedge clk);
    clear_strobes();
    k = 0;
    while (mem_req === 1'b1 && k < 40) begin
      if (k == d) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      if (k == 1 && mid_mar >= 0) begin
        r32 = mid_mar; bus_in = r32; MARin = 1'b1; m_mar = r32[8:0];
      end else if (junk) begin
        r32 = $urandom; bus_in = r32;
        case ($urandom_range(0, 3))
          1: begin MDRin = 1'b1; Read = 1'b1; end
          2: ramWE = 1'b1;
          3: begin MDRin = 1'b1; Read = 1'b0; end
          default: ;
        endcase
        if ($urandom_range(0, 3) == 0) begin
          MARin = 1'b1; m_mar = r32[8:0];
        end
      end
      @(posedge clk); @(negedge clk);
      clear_strobes();
      k++;
    end
    check("access_bounded", k < 40, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = $urandom;
    ram[9'h055] = 32'h1234_5678;

    // Power-on reset state
    repeat (3) @(negedge clk);
    check("rst_mdr", mdr_out, 0);
    check("rst_mar", mar_out, 0);
    check("rst_req", mem_req, 0);
    check("rst_busy", mem_busy, 0);
    check("rst_done", mem_done, 0);
    check("rst_err", bus_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Reset asserted in the middle of a read drops everything at once
    set_mar(32'h0000_0033);
    load_mdr(32'h0BAD_F00D);
    MDRin = 1'b1; Read = 1'b1;
    @(posedge clk); @(negedge clk);
    MDRin = 1'b0; Read = 1'b0;
    check("midrd_req", mem_req, 1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_req", mem_req, 0);
    check("async_rst_busy", mem_busy, 0);
    check("async_rst_mdr", mdr_out, 0);
    check("async_rst_mar", mar_out, 0);
    @(negedge clk);
    rst = 1'b1;
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    @(negedge clk);
    check("no_resume_req", mem_req, 0);
    mon_en = 1'b1;

    // MAR and MDR bus loads
    set_mar(32'h0000_0055);
    load_mdr(32'hDEAD_BEEF);

    // Read with ack after 3 cycles
    access(1'b0, 1'b0, 3, 1'b0, -1);
    check("read_result", mdr_out, 32'h1234_5678);

    // Write to top address, MAR changed mid-access
    load_mdr(32'hCAFE_0001);
    set_mar(32'h0000_01FF);
    access(1'b1, 1'b0, 4, 1'b0, 32'h010);
    check("mar_mid_access", mar_out, 9'h010);

    // Read timeout, then a normal access
    access(1'b0, 1'b0, 20, 1'b0, -1);
    check("err_sticky", bus_err, 1);
    set_mar(32'h0000_01FF);
    access(1'b0, 1'b0, 1, 1'b0, -1);
    check("read_back_write", mdr_out, 32'hCAFE_0001);

    // Ack on the timeout edge completes normally; ack on first cycle
    access(1'b0, 1'b0, TO - 1, 1'b0, -1);
    access(1'b1, 1'b0, 0, 1'b0, -1);

    // Write has priority; strobes while busy are ignored
    load_mdr(32'h5A5A_A5A5);
    access(1'b0, 1'b1, 5, 1'b1, -1);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 3))
        0: set_mar($urandom);
        1: load_mdr($urandom);
        default: access($urandom_range(0, 1), $urandom_range(0, 7) == 0,
                        ($urandom_range(0, 5) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 6),
                        1'b1, -1);
      endcase
    end

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
